// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard unit: mult/div op kind, scheduler states, latencies.
package hazard_ctrl_pkg;

   // Operation kind carried on MultIsDivE
   typedef enum logic {
      MULT_MUL = 1'b0,
      MULT_DIV = 1'b1
   } mult_t;

   // Mult/div scheduler states
   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } mdState_t;

   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 32;
   localparam int CNT_W   = 6;

   // Register 0 is hardwired, so it never creates a dependency
   function automatic logic regHit(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle. master = pipeline side, slave = hazard unit.
interface hazard_ctrl_if;
   // decode
   logic [4:0] RsD, RtD;
   logic       BranchD;
   // execute
   logic [4:0] RsE, RtE, WriteRegE;
   logic       RegWriteE, MemtoRegE;
   logic       MultStartE, MultIsDivE;
   // memory / writeback
   logic [4:0] WriteRegM, WriteRegW;
   logic       RegWriteM, MemtoRegM, RegWriteW;
   // bus waits / exceptions
   logic       IStall, DStall, ExcM;
   // pipeline control
   logic       StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushM, FlushW;
   // forwarding
   logic       ForwardAD, ForwardBD;
   logic [1:0] ForwardAE, ForwardBE;
   // mult/div status
   logic       MultBusy, MultDoneE;

   modport master (
      output RsD, RtD, BranchD,
      output RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, MultStartE, MultIsDivE,
      output WriteRegM, WriteRegW, RegWriteM, MemtoRegM, RegWriteW,
      output IStall, DStall, ExcM,
      input  StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushM, FlushW,
      input  ForwardAD, ForwardBD, ForwardAE, ForwardBE,
      input  MultBusy, MultDoneE
   );

   modport slave (
      input  RsD, RtD, BranchD,
      input  RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, MultStartE, MultIsDivE,
      input  WriteRegM, WriteRegW, RegWriteM, MemtoRegM, RegWriteW,
      input  IStall, DStall, ExcM,
      output StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushM, FlushW,
      output ForwardAD, ForwardBD, ForwardAE, ForwardBE,
      output MultBusy, MultDoneE
   );
endinterface

// File: rtl/hazard_ctrl_multdiv_sched.sv
// Multi-cycle mult/div scheduler: holds E while the iterative unit works,
// then presents DONE until the pipeline lets E advance.
module multdiv_sched
   import hazard_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic MultStartE,
   input  logic MultIsDivE,
   input  logic StallE,
   input  logic ExcM,
   output logic multStall,
   output logic MultBusy,
   output logic MultDoneE
);

   localparam logic [1:0] ST_IDLE = MD_IDLE;
   localparam logic [1:0] ST_BUSY = MD_BUSY;
   localparam logic [1:0] ST_DONE = MD_DONE;

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

   logic [1:0]       state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   mult_t            opKind;

   assign opKind = mult_t'(MultIsDivE);

   // Next-state: start loads the latency, BUSY counts down, DONE waits for E to move
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      case (state)
         ST_IDLE: if (MultStartE) begin
            stateNext = ST_BUSY;
            cntNext   = (opKind == MULT_DIV) ? DIV_CNT : MUL_CNT;
         end
         ST_BUSY: if (cnt != '0) cntNext = cnt - 1'b1;
                  else           stateNext = ST_DONE;
         ST_DONE: if (!StallE) stateNext = ST_IDLE;
         default: stateNext = ST_IDLE;
      endcase
      // an exception squashes the in-flight op
      if (ExcM) begin
         stateNext = ST_IDLE;
         cntNext   = '0;
      end
   end

   // State/count registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   assign multStall = ((state == ST_IDLE) && MultStartE) || (state == ST_BUSY);
   assign MultBusy  = (state == ST_BUSY);
   assign MultDoneE = (state == ST_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: operand forwarding, load-use/branch interlocks, bus-wait and
// mult/div stalls, and exception flush.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave hz
);

   logic multStall, loadStall, branchStall, stallE;
   logic sF, sD, sE, sM;
   logic fD, fE, fM, fW;

   multdiv_sched uSched (
      .clk        (clk),
      .reset      (reset),
      .MultStartE (hz.MultStartE),
      .MultIsDivE (hz.MultIsDivE),
      .StallE     (stallE),
      .ExcM       (hz.ExcM),
      .multStall  (multStall),
      .MultBusy   (hz.MultBusy),
      .MultDoneE  (hz.MultDoneE)
   );

   // Forwarding muxes: M result beats W result
   always_comb begin
      hz.ForwardAE = 2'b00;
      if (hz.RegWriteM && regHit(hz.WriteRegM, hz.RsE))      hz.ForwardAE = 2'b10;
      else if (hz.RegWriteW && regHit(hz.WriteRegW, hz.RsE)) hz.ForwardAE = 2'b01;
      hz.ForwardBE = 2'b00;
      if (hz.RegWriteM && regHit(hz.WriteRegM, hz.RtE))      hz.ForwardBE = 2'b10;
      else if (hz.RegWriteW && regHit(hz.WriteRegW, hz.RtE)) hz.ForwardBE = 2'b01;
      hz.ForwardAD = hz.RegWriteM && regHit(hz.WriteRegM, hz.RsD);
      hz.ForwardBD = hz.RegWriteM && regHit(hz.WriteRegM, hz.RtD);
   end

   // Data-dependency interlocks seen by the decode stage
   always_comb begin
      loadStall = hz.MemtoRegE && hz.RegWriteE &&
                  (regHit(hz.WriteRegE, hz.RsD) || regHit(hz.WriteRegE, hz.RtD));
      branchStall = hz.BranchD &&
                  ((hz.RegWriteE && (regHit(hz.WriteRegE, hz.RsD) || regHit(hz.WriteRegE, hz.RtD))) ||
                   (hz.MemtoRegM && (regHit(hz.WriteRegM, hz.RsD) || regHit(hz.WriteRegM, hz.RtD))));
   end

   // Stall/flush priority: exception > data bus > mult/div > interlock > ifetch.
   // Each cause freezes the stages up to its own and bubbles the next one.
   always_comb begin
      {sF, sD, sE, sM} = 4'b0000;
      {fD, fE, fM, fW} = 4'b0000;
      if (hz.ExcM) begin
         {fD, fE, fM} = 3'b111;
      end else if (hz.DStall) begin
         {sF, sD, sE, sM} = 4'b1111;
         fW = 1'b1;
      end else if (multStall) begin
         {sF, sD, sE} = 3'b111;
         fM = 1'b1;
      end else if (loadStall || branchStall) begin
         {sF, sD} = 2'b11;
         fE = 1'b1;
      end else if (hz.IStall) begin
         sF = 1'b1;
         fD = 1'b1;
      end
   end

   // Flush always beats stall on the same stage
   assign hz.StallF = sF;
   assign hz.StallD = sD & ~fD;
   assign stallE    = sE & ~fE;
   assign hz.StallE = stallE;
   assign hz.StallM = sM & ~fM;
   assign hz.FlushD = fD;
   assign hz.FlushE = fE;
   assign hz.FlushM = fM;
   assign hz.FlushW = fW;

endmodule
